// File: rtl/ipf_lcu_feeder.sv
// ipf_lcu_feeder: upstream stage of the in-loop pixel filter.
// Walks a 128x128 8-bit frame one LCU at a time. For each LCU it fetches the
// filter parameters, then streams the LCU's pixels in raster order, in groups
// paced by the filter's busy handshake.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   start, cfg_lcu_size frame start pulse and LCU size code (0=16, 1=32, 2/3=64)
//   iaddr / idata       frame ROM address and data (data one cycle after address)
//   par_addr / par_data parameter ROM address and data (data one cycle after address)
//   busy                filter busy; rises the cycle after the last pixel of a group
//   in_en / din         pixel valid and pixel to the filter
//   ipf_*, lcu_*        per-LCU filter parameters and LCU position/size
//   done                one-cycle pulse when the whole frame has been delivered
module ipf_lcu_feeder #(
    parameter int unsigned IMG_W = 128,
    parameter int unsigned AW    = 14
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [1:0]    cfg_lcu_size,
    output logic [AW-1:0] iaddr,
    input  logic [7:0]    idata,
    output logic [5:0]    par_addr,
    input  logic [23:0]   par_data,
    input  logic          busy,
    output logic          in_en,
    output logic [7:0]    din,
    output logic [1:0]    ipf_type,
    output logic [4:0]    ipf_band_pos,
    output logic          ipf_wo_class,
    output logic [15:0]   ipf_offset,
    output logic [2:0]    lcu_x,
    output logic [2:0]    lcu_y,
    output logic [1:0]    lcu_size,
    output logic          done
);

    localparam int unsigned ColW = $clog2(IMG_W);

    typedef enum logic [2:0] {
        StIdle,
        StParam,
        StStream,
        StDrain,
        StWaitBusy,
        StDone
    } state_e;

    state_e state_q, state_d;

    logic [1:0]  size_q, size_d;
    logic [2:0]  x_q, x_d, y_q, y_d;
    logic [5:0]  r_q, r_d, c_q, c_d;
    logic        pcnt_q, pcnt_d;
    // Pixel pipeline: iss_q marks a valid iaddr, dv_q a valid idata.
    logic        iss_q, iss_d, dv_q;

    logic [AW-1:0] iaddr_q;
    logic [5:0]    par_addr_q;
    logic          in_en_q, done_q;
    logic [7:0]    din_q;
    logic [1:0]    ipf_type_q;
    logic [4:0]    ipf_band_pos_q;
    logic          ipf_wo_class_q;
    logic [15:0]   ipf_offset_q;
    logic [2:0]    lcu_x_q, lcu_y_q;
    logic [1:0]    lcu_size_q;

    // Geometry derived from the latched size; code 3 aliases code 2.
    logic [1:0] s_eff;
    logic [5:0] n_m1;
    logic [2:0] l_m1;
    logic       last_c, grp_end;
    logic [6:0] row, col;
    logic [5:0] idx_d;

    always_comb begin
        s_eff   = (size_q == 2'd3) ? 2'd2 : size_q;
        n_m1    = {s_eff == 2'd2, s_eff != 2'd0, 4'hf};
        l_m1    = 3'd7 >> s_eff;
        last_c  = (c_q == n_m1);
        // Group 0 covers rows 0..2, every later group a single row.
        grp_end = last_c && (r_q >= 6'd2);
        row     = (7'(x_q) << (3'd4 + 3'(s_eff))) + 7'(r_q);
        col     = (7'(y_q) << (3'd4 + 3'(s_eff))) + 7'(c_q);
        idx_d   = (6'(x_d) << (2'd3 - s_eff)) + 6'(y_d);
    end

    always_comb begin
        state_d = state_q;
        size_d  = size_q;
        x_d     = x_q;
        y_d     = y_q;
        r_d     = r_q;
        c_d     = c_q;
        pcnt_d  = 1'b0;
        iss_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start && !busy) begin
                    size_d  = cfg_lcu_size;
                    x_d     = '0;
                    y_d     = '0;
                    r_d     = '0;
                    c_d     = '0;
                    state_d = StParam;
                end
            end
            StParam: begin
                pcnt_d = 1'b1;
                if (pcnt_q) begin
                    pcnt_d  = 1'b0;
                    state_d = StStream;
                end
            end
            StStream: begin
                iss_d = 1'b1;
                c_d   = last_c ? 6'd0 : c_q + 6'd1;
                if (last_c) begin
                    r_d = (r_q == n_m1) ? 6'd0 : r_q + 6'd1;
                end
                if (grp_end) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                // Leave once the last pixel of the group has gone out on in_en.
                if (!iss_q && !dv_q && !in_en_q) begin
                    state_d = StWaitBusy;
                end
            end
            StWaitBusy: begin
                if (!busy) begin
                    // r wraps to 0 only after the final row of the LCU.
                    if (r_q != 6'd0) begin
                        state_d = StStream;
                    end else if (y_q != l_m1) begin
                        y_d     = y_q + 3'd1;
                        state_d = StParam;
                    end else if (x_q != l_m1) begin
                        y_d     = '0;
                        x_d     = x_q + 3'd1;
                        state_d = StParam;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= StIdle;
            size_q         <= '0;
            x_q            <= '0;
            y_q            <= '0;
            r_q            <= '0;
            c_q            <= '0;
            pcnt_q         <= 1'b0;
            iss_q          <= 1'b0;
            dv_q           <= 1'b0;
            iaddr_q        <= '0;
            par_addr_q     <= '0;
            in_en_q        <= 1'b0;
            din_q          <= '0;
            done_q         <= 1'b0;
            ipf_type_q     <= '0;
            ipf_band_pos_q <= '0;
            ipf_wo_class_q <= 1'b0;
            ipf_offset_q   <= '0;
            lcu_x_q        <= '0;
            lcu_y_q        <= '0;
            lcu_size_q     <= '0;
        end else begin
            state_q <= state_d;
            size_q  <= size_d;
            x_q     <= x_d;
            y_q     <= y_d;
            r_q     <= r_d;
            c_q     <= c_d;
            pcnt_q  <= pcnt_d;
            iss_q   <= iss_d;
            dv_q    <= iss_q;
            in_en_q <= dv_q;
            done_q  <= (state_d == StDone);
            if (state_q == StStream) begin
                iaddr_q <= AW'({row, col});
            end
            if (dv_q) begin
                din_q <= idata;
            end
            // Address goes out on entry so data is back for the second PARAM cycle.
            if (state_d == StParam && state_q != StParam) begin
                par_addr_q <= idx_d;
            end
            if (state_q == StParam && pcnt_q) begin
                ipf_type_q     <= par_data[23:22];
                ipf_band_pos_q <= par_data[21:17];
                ipf_wo_class_q <= par_data[16];
                ipf_offset_q   <= par_data[15:0];
                lcu_x_q        <= x_q;
                lcu_y_q        <= y_q;
                lcu_size_q     <= size_q;
            end
        end
    end

    assign iaddr        = iaddr_q;
    assign par_addr     = par_addr_q;
    assign in_en        = in_en_q;
    assign din          = din_q;
    assign ipf_type     = ipf_type_q;
    assign ipf_band_pos = ipf_band_pos_q;
    assign ipf_wo_class = ipf_wo_class_q;
    assign ipf_offset   = ipf_offset_q;
    assign lcu_x        = lcu_x_q;
    assign lcu_y        = lcu_y_q;
    assign lcu_size     = lcu_size_q;
    assign done         = done_q;

endmodule

// File: doc/ipf_lcu_feeder.md
Name: ipf_lcu_feeder

Overview:
- Upstream stage of the in-loop pixel filter (IPF).
- Walks a 128x128 8-bit frame stored in an external frame ROM, one LCU at a time, and streams each LCU's pixels in raster order on the filter's in_en/din interface.
- Fetches per-LCU filter parameters from a parameter ROM and drives them together with lcu_x/lcu_y/lcu_size.
- Paces the stream into the groups the filter expects and obeys its busy handshake.

Parameters:
- IMG_W, 128, frame width and height in pixels (fixed square frame).
- AW, 14, frame ROM address width (log2 of IMG_W*IMG_W).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  one-cycle pulse; begins a frame when in IDLE
- cfg_lcu_size  input  2  LCU size code, sampled on accepted start: 0=16, 1=32, 2=64, 3=reserved (treated as 64)
- iaddr  output  AW  frame ROM address, row*128+col
- idata  input  8  frame ROM data, valid one cycle after iaddr
- par_addr  output  6  parameter ROM address, LCU index lcu_x*(128/N)+lcu_y
- par_data  input  24  {type[23:22], band_pos[21:17], wo_class[16], offset[15:0]}, valid one cycle after par_addr
- busy  input  1  filter busy; it rises the cycle after the filter accepts the last pixel of a group
- in_en  output  1  pixel valid to filter
- din  output  8  pixel to filter
- ipf_type  output  2  filter type of the current LCU
- ipf_band_pos  output  5  band position of the current LCU
- ipf_wo_class  output  1  WO class of the current LCU
- ipf_offset  output  16  offsets of the current LCU
- lcu_x  output  3  LCU vertical index (LCU row)
- lcu_y  output  3  LCU horizontal index (LCU column)
- lcu_size  output  2  latched size code
- done  output  1  one-cycle pulse when the frame is fully delivered and the filter is idle

Behaviour:
- Clock and reset: single clock clk; reset is asynchronous, active-high.
- Reset values: all outputs 0; state IDLE. Reset mid-frame aborts immediately, with no done pulse.
- Registered outputs: every output is registered.
- Parameter latching: ipf_* and lcu_* change only in PARAM and are held constant for the whole LCU.
- LCU geometry:
  - N = 16 << min(size, 2); L = 128/N LCUs per dimension.
  - LCU order: lcu_y inner (0..L-1), lcu_x outer.
  - Pixel (r,c) of LCU (x,y) is at iaddr = ((x*N + r) << 7) + y*N + c.
- Groups per LCU:
  - G0 = rows 0..2 (3N pixels).
  - Then one group per row, for rows 3..N-1 (N-3 groups).
  - N-2 groups in total per LCU.
- FSM states: IDLE, PARAM, STREAM, DRAIN, WAIT_BUSY, DONE.
- IDLE:
  - start=1 and busy=0 -> latch size, clear x/y/r/c, go to PARAM.
  - start in any other state is ignored.
- PARAM:
  - Drive par_addr in cycle 1; register par_data fields onto the ipf_* outputs at the end of cycle 2.
  - Then go to STREAM. PARAM takes 2 cycles.
- STREAM:
  - Issue one iaddr per cycle, advancing c, then r.
  - Pipeline: iaddr in cycle k; idata registered into din with in_en=1 in cycle k+2. Fixed latency of 2, no bubbles within a group.
  - After issuing the last address of a group, go to DRAIN.
- DRAIN: wait until the last pixel of the group has left in_en, plus one further cycle (busy is then high), then go to WAIT_BUSY.
- WAIT_BUSY: when busy=0:
  - next group in the same LCU -> STREAM;
  - else next LCU -> PARAM (advance y; on wrap, y=0 and x+1);
  - after the last group of LCU (L-1, L-1) -> DONE.
- DONE: done=1 for one cycle, then IDLE.
- in_en: 0 in every state except the two cycles after STREAM issues an address. Never asserted while busy=1.
- Protocol error: busy=1 observed in STREAM is ignored (it is a filter protocol violation).
- Address arithmetic: 14-bit unsigned. N*L = 128, so addresses never wrap.
- Size code 3 behaves exactly as size code 2.

Test Plan:
- Size 0, ROM[a]=a[7:0], filter model raising busy 1 cycle after each group end for 5 cycles -> 64 LCUs; first in_en burst of 48 pixels has din 0..15, 128..143, 0..15 (row 2 = 256..271 mod 256); bursts of 16 thereafter; single done pulse at the end.
- Size 2 -> exactly 4 LCUs in order (x,y) = (0,0), (0,1), (1,0), (1,1); 62 groups each; second LCU first iaddr = 64; done after 16384 in_en cycles total.
- Parameter ROM with par_data=24'hABCDEF for LCU 1 -> ipf_type=2, band_pos=5'h15, wo_class=1, offset=16'hCDEF, stable across all in_en of that LCU.
- Busy held high 100 cycles after a group -> no in_en during those cycles; stream resumes 1 cycle after busy falls; data contiguous with no lost pixel.
- Reset asserted mid-STREAM -> in_en, done and all outputs 0 immediately; a new start restarts at iaddr 0 and LCU (0,0).
- start pulsed during STREAM, or while busy=1 in IDLE -> ignored: no restart, counters unchanged.
